// File: rtl/main_memory_ctrl.sv
// Line-burst main memory behind a cache controller: fixed access latency, then one byte beat per cycle.
// Requests are accepted only in IDLE; reads return mem_rvalid beats, writes consume mem_wdata on mem_wack beats.
module main_memory_ctrl #(
  parameter int LINE_BYTES = 16,
  parameter int LATENCY    = 4,
  parameter int MEM_BYTES  = 4096
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [7:0]  mem_wdata,
  output logic [7:0]  mem_rdata,
  output logic        mem_rvalid,
  output logic        mem_wack,
  output logic [3:0]  mem_beat,
  output logic        mem_busy,
  output logic        mem_done
);

  localparam int AW = $clog2(MEM_BYTES);
  localparam int LB = $clog2(LINE_BYTES);

  typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} state_t;

  state_t         state_q;
  logic [3:0]     cnt_q;
  logic [AW-LB-1:0] line_q;
  logic           we_q;
  logic [3:0]     beat_q;
  logic [7:0]     rdata_q;
  logic           rvalid_q;
  logic           wack_q;
  logic           busy_q;
  logic           done_q;

  // Storage holds (content XOR address): the all-zero power-up state reads back as storage[i] = i[7:0].
  logic [7:0]     delta_q [MEM_BYTES];

  logic [LB-1:0]  rd_beat;
  logic [AW-1:0]  rd_addr;
  logic [AW-1:0]  wr_addr;
  logic [7:0]     rd_byte;
  logic           unused_addr_bits;

  assign unused_addr_bits = ^{mem_addr[31:AW], mem_addr[LB-1:0]};

  always_comb begin
    rd_beat = '0;
    if (state_q == BURST) rd_beat = beat_q[LB-1:0] + LB'(1);
    rd_addr = {line_q, rd_beat};
    wr_addr = {line_q, beat_q[LB-1:0]};
    rd_byte = delta_q[rd_addr] ^ 8'(rd_addr);
  end

  // wack_q is cleared asynchronously by reset, so a reset mid-burst stops further writes at once.
  always_ff @(posedge clk) begin
    if (wack_q) delta_q[wr_addr] <= mem_wdata ^ 8'(wr_addr);
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      line_q   <= '0;
      we_q     <= 1'b0;
      beat_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      wack_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mem_req) begin
            line_q  <= mem_addr[AW-1:LB];
            we_q    <= mem_we;
            cnt_q   <= 4'(LATENCY);
            busy_q  <= 1'b1;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == 4'd1) begin
            state_q  <= BURST;
            cnt_q    <= '0;
            beat_q   <= '0;
            rvalid_q <= ~we_q;
            wack_q   <= we_q;
            rdata_q  <= we_q ? 8'h00 : rd_byte;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        BURST: begin
          if (beat_q == 4'(LINE_BYTES - 1)) begin
            state_q  <= DONE;
            beat_q   <= '0;
            rvalid_q <= 1'b0;
            wack_q   <= 1'b0;
            rdata_q  <= '0;
            done_q   <= 1'b1;
          end else begin
            beat_q <= beat_q + 4'd1;
            if (!we_q) rdata_q <= rd_byte;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_rdata  = rdata_q;
  assign mem_rvalid = rvalid_q;
  assign mem_wack   = wack_q;
  assign mem_beat   = beat_q;
  assign mem_busy   = busy_q;
  assign mem_done   = done_q;

endmodule

// File: tb/tb_main_memory_ctrl.sv
// Scoreboard bench for main_memory_ctrl: stimulus queues expected beats, a negedge monitor pops and compares.
module tb_main_memory_ctrl;

  localparam int LBYTES = 16;
  localparam int LAT    = 4;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_rvalid;
  logic        mem_wack;
  logic [3:0]  mem_beat;
  logic        mem_busy;
  logic        mem_done;

  always #5 clk = ~clk;

  main_memory_ctrl #(.LINE_BYTES(LBYTES), .LATENCY(LAT), .MEM_BYTES(4096)) dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid),
    .mem_wack   (mem_wack),
    .mem_beat   (mem_beat),
    .mem_busy   (mem_busy),
    .mem_done   (mem_done)
  );

  typedef struct packed {
    logic       we;
    logic [3:0] beat;
    logic [7:0] data;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] wq[$];
  exp_t       e;
  logic       ack;
  int         errors = 0;
  int         checks = 0;
  int         exp_done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req_v);
    end
  endtask

  // Monitor: every presented beat and done pulse is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst_b) begin
      if (mem_rvalid && mem_wack) begin
        checks++; errors++;
        $display("FAIL rvalid_wack_exclusive: both high at beat %0d", mem_beat);
      end
      if ((mem_rvalid || mem_wack) && !mem_busy) begin
        checks++; errors++;
        $display("FAIL beat_without_busy: beat %0d with busy=0", mem_beat);
      end
      if (mem_rvalid || mem_wack) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat: we=%0d beat=%0d data=0x%0h, expected none", mem_wack, mem_beat, mem_rdata);
        end else begin
          e = sb.pop_front();
          chk("beat", {19'd0, mem_wack, mem_beat, (mem_wack ? 8'h00 : mem_rdata)},
                      {19'd0, e.we, e.beat, (e.we ? 8'h00 : e.data)});
        end
      end
      if (mem_done) begin
        checks++;
        if (exp_done == 0) begin
          errors++;
          $display("FAIL unexpected_done: done pulse with none outstanding");
        end else begin
          exp_done--;
        end
      end
    end
  end

  // Write-data driver: presents the head of wq and advances after each acknowledged beat.
  always begin
    @(posedge clk);
    ack = mem_wack;
    #1;
    if (ack && wq.size() > 0) void'(wq.pop_front());
    mem_wdata = (wq.size() > 0) ? wq[0] : 8'h00;
  end

  task automatic do_req(input logic we, input logic [31:0] addr, input logic hold,
                        input logic [7:0] ex [16]);
    int n, first_n, done_n, idle_n;
    for (int k = 0; k < LBYTES; k++) begin
      sb.push_back({we, 4'(k), ex[k]});
      if (we) wq.push_back(ex[k]);
    end
    exp_done++;
    mem_req  = 1'b1;
    mem_we   = we;
    mem_addr = addr;
    @(posedge clk); #1;
    mem_req  = hold;
    mem_we   = hold ? 1'b0 : ~we;
    mem_addr = 32'h0000_0200;
    n = 0; first_n = 0; done_n = 0; idle_n = 0;
    while (idle_n == 0 && n < 100) begin
      @(negedge clk);
      n++;
      if (first_n == 0 && (mem_rvalid || mem_wack)) first_n = n;
      if (done_n == 0 && mem_done) done_n = n;
      if (!mem_busy) begin
        idle_n  = n;
        mem_req = 1'b0;
      end
    end
    mem_req = 1'b0;
    chk("first_beat_latency", first_n, LAT + 1);
    chk("done_cycle", done_n, LAT + LBYTES + 1);
    chk("idle_cycle", idle_n, LAT + LBYTES + 2);
    chk("sb_drained", sb.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] ex [16];
    int n;
    logic found;
    rst_b = 1'b0; mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {18'd0, mem_rdata, mem_rvalid, mem_wack, mem_beat, mem_busy, mem_done}, 0);
    rst_b = 1'b1;

    for (int k = 0; k < 16; k++) ex[k] = 8'h10 + 8'(k);
    do_req(1'b0, 32'h0000_0010, 1'b0, ex);

    for (int k = 0; k < 16; k++) ex[k] = 8'hA5 + 8'(k);
    do_req(1'b1, 32'h0000_0080, 1'b0, ex);
    do_req(1'b0, 32'h0000_0080, 1'b0, ex);

    for (int k = 0; k < 16; k++) ex[k] = 8'(k);
    do_req(1'b0, 32'h0000_1104, 1'b0, ex);

    for (int k = 0; k < 16; k++) ex[k] = 8'h10 + 8'(k);
    do_req(1'b0, 32'h0000_0010, 1'b1, ex);
    repeat (3) @(posedge clk);
    #1;
    chk("collision_no_extra_done", exp_done, 0);
    for (int k = 0; k < 16; k++) ex[k] = 8'(k);
    do_req(1'b0, 32'h0000_0200, 1'b0, ex);

    for (int k = 0; k < 16; k++) wq.push_back(8'hD8 + 8'(k));
    for (int k = 0; k < 6; k++) sb.push_back({1'b1, 4'(k), 8'hD8 + 8'(k)});
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h0000_0400;
    @(posedge clk); #1;
    mem_req = 1'b0;
    n = 0; found = 1'b0;
    while (!found && n < 100) begin
      @(negedge clk);
      n++;
      if (mem_wack && mem_beat == 4'd5) found = 1'b1;
    end
    chk("reset_test_beat5_seen", {31'd0, found}, 1);
    @(posedge clk); #1;
    rst_b = 1'b0;
    #1;
    chk("midburst_reset_outputs", {18'd0, mem_rdata, mem_rvalid, mem_wack, mem_beat, mem_busy, mem_done}, 0);
    wq.delete();
    repeat (2) @(posedge clk);
    #1;
    chk("sb_after_reset", sb.size(), 0);
    rst_b = 1'b1;

    for (int k = 0; k < 16; k++) ex[k] = (k < 6) ? 8'hD8 + 8'(k) : 8'(k);
    do_req(1'b0, 32'h0000_0400, 1'b0, ex);

    repeat (2) @(posedge clk);
    #1;
    chk("final_sb_empty", sb.size(), 0);
    chk("final_done_outstanding", exp_done, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/main_memory_ctrl.md
MAIN_MEMORY_CTRL -- requirements
Module: main_memory_ctrl

Interface
REQ-001 Parameters SHALL be: LINE_BYTES, default 16, bytes per line burst; LATENCY, default 4, access cycles before first beat (range 1..15); MEM_BYTES, default 4096, storage size, power of two.
REQ-002 Ports SHALL be, clock and reset first, name direction width meaning:
- clk  in  1  single clock, rising edge.
- rst_b  in  1  reset, asynchronous, active-low.
- mem_req  in  1  line request from cache_controller, sampled only in IDLE.
- mem_we  in  1  1 = line write-back, 0 = line fill; sampled with mem_req.
- mem_addr  in  32  byte address; line base = mem_addr with low log2(LINE_BYTES) bits cleared.
- mem_wdata  in  8  write beat data, sampled when mem_wack=1.
- mem_rdata  out  8  read beat data, valid when mem_rvalid=1.
- mem_rvalid  out  1  read beat valid.
- mem_wack  out  1  write beat consumed this cycle.
- mem_beat  out  4  current beat index 0..LINE_BYTES-1.
- mem_busy  out  1  request in progress.
- mem_done  out  1  one-cycle completion pulse.

Function
REQ-003 The FSM SHALL have states IDLE, WAIT, BURST, DONE; all outputs SHALL be registered.
REQ-004 In IDLE with mem_req=1 at edge E0: latch line base and mem_we, load latency counter with LATENCY, enter WAIT; mem_busy=1 from E0.
REQ-005 mem_req in WAIT, BURST or DONE SHALL be ignored (no queueing); mem_addr/mem_we changes after E0 SHALL have no effect.
REQ-006 WAIT SHALL last exactly LATENCY cycles, then enter BURST with beat index 0.
REQ-007 Beat k (k=0..LINE_BYTES-1) SHALL be presented in the cycle after edge E0+LATENCY+k; mem_beat=k in that cycle.
REQ-008 Read burst: mem_rvalid=1 and mem_rdata=storage[(base+k) mod MEM_BYTES] for every beat, no gaps.
REQ-009 Write burst: mem_wack=1 for every beat; mem_wdata SHALL be written to storage[(base+k) mod MEM_BYTES] at the edge ending that cycle; cache_controller advances mem_wdata after each acknowledged beat.
REQ-010 mem_rvalid and mem_wack SHALL never be 1 simultaneously, and SHALL be 0 outside BURST.
REQ-011 After the last beat: DONE for exactly one cycle (mem_done=1, mem_busy=1), then IDLE (mem_busy=0); earliest next accept is the first IDLE cycle.
REQ-012 Address bits at and above log2(MEM_BYTES) SHALL be ignored (aliasing); a line never straddles the wrap since MEM_BYTES is a multiple of LINE_BYTES.
REQ-013 Beat index SHALL count 0..LINE_BYTES-1 without wrap inside a burst; total request time = LATENCY+LINE_BYTES+1 cycles from E0 to return to IDLE.
REQ-014 Storage SHALL be byte-wide, MEM_BYTES entries, initial content storage[i]=i[7:0] at time 0.

Reset
REQ-015 rst_b=0 SHALL immediately force IDLE and mem_rdata=0x00, mem_rvalid=0, mem_wack=0, mem_beat=0, mem_busy=0, mem_done=0, counters cleared.
REQ-016 Reset SHALL NOT modify storage; reset mid-write-burst SHALL keep beats already written and write no further beats.
REQ-017 Requests SHALL be accepted from the first rising edge after rst_b deasserts.

Verification
REQ-018 Read fill: mem_req=1, mem_we=0, mem_addr=0x00000010 -> after LATENCY+1 cycles 16 consecutive beats mem_rdata=0x10..0x1F, mem_beat 0..15, then one mem_done pulse, mem_busy low next cycle.
REQ-019 Write-back then refill: write line 0x00000080 with 0xA5,0xA6..0xB4 -> 16 mem_wack beats; read 0x00000080 -> same 16 bytes in order.
REQ-020 Unaligned/alias: read mem_addr=0x00001104 -> beats return storage 0x100..0x10F (values 0x00..0x0F).
REQ-021 Busy collision: second mem_req (addr 0x200) held during an active read of 0x10 -> ignored; only one mem_done; 0x200 read only if re-requested in IDLE.
REQ-022 Reset mid-burst: write line 0x400 with 0xD8.., assert rst_b=0 after beat 5 -> all outputs 0 at once; subsequent read of 0x400 returns 6 written bytes then original 0x06..0x0F.
